// File: rtl/time_hm_counter_if.sv
// Increment-level inputs and BCD time outputs of the hour/minute counter.
// master drives the increment levels; slave is the counter itself.
interface time_hm_counter_if;
  logic       inc_m;
  logic       inc_h;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       m_out;
  logic       pm;

  modport master (
    output inc_m, inc_h,
    input  min_bcd, hour_bcd, m_out, pm
  );

  modport slave (
    input  inc_m, inc_h,
    output min_bcd, hour_bcd, m_out, pm
  );
endinterface

// File: rtl/time_hm_counter.sv
// BCD minute/hour counter with synchronised, edge-detected increment inputs.
// Optional 12-hour mode with PM flag is enabled by defining HOUR12_EN.
module time_hm_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int CARRY_LEN   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  time_hm_counter_if.slave   bus
);

  localparam int CW = (CARRY_LEN > 1) ? $clog2(CARRY_LEN + 1) : 1;

`ifdef HOUR12_EN
  localparam logic [7:0] HOUR_RST = 8'h12;
`else
  localparam logic [7:0] HOUR_RST = 8'h00;
`endif

  logic [SYNC_STAGES-1:0] r_sync_m, r_sync_h;
  logic                   r_prev_m, r_prev_h;
  logic                   w_step_m, w_step_h;

  logic [3:0] r_min_t, r_min_u, r_hour_t, r_hour_u;
  logic [3:0] w_min_t_nxt, w_min_u_nxt, w_hour_t_nxt, w_hour_u_nxt;
  logic       w_min_wrap, w_pm_toggle;
  logic [CW-1:0] r_carry_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_m <= '0;
      r_sync_h <= '0;
      r_prev_m <= 1'b0;
      r_prev_h <= 1'b0;
    end else begin
      r_sync_m <= {r_sync_m[SYNC_STAGES-2:0], bus.inc_m};
      r_sync_h <= {r_sync_h[SYNC_STAGES-2:0], bus.inc_h};
      r_prev_m <= r_sync_m[SYNC_STAGES-1];
      r_prev_h <= r_sync_h[SYNC_STAGES-1];
    end
  end

  assign w_step_m = r_sync_m[SYNC_STAGES-1] & ~r_prev_m;
  assign w_step_h = r_sync_h[SYNC_STAGES-1] & ~r_prev_h;

  // NOTE: every output of a combinational block gets a default first,
  // otherwise untaken branches would infer latches.
  always_comb begin
    w_min_t_nxt = r_min_t;
    w_min_u_nxt = r_min_u;
    w_min_wrap  = 1'b0;
    if (w_step_m) begin
      if (r_min_u >= 4'd9) begin
        w_min_u_nxt = 4'd0;
        if (r_min_t >= 4'd5) begin
          w_min_t_nxt = 4'd0;
          w_min_wrap  = 1'b1;
        end else begin
          w_min_t_nxt = r_min_t + 4'd1;
        end
      end else begin
        w_min_u_nxt = r_min_u + 4'd1;
      end
    end
  end

  always_comb begin
    w_hour_t_nxt = r_hour_t;
    w_hour_u_nxt = r_hour_u;
    w_pm_toggle  = 1'b0;
    if (w_step_h) begin
`ifdef HOUR12_EN
      // 12 wraps to 01; 11 -> 12 is the AM/PM boundary.
      if (r_hour_t == 4'd1 && r_hour_u >= 4'd2) begin
        w_hour_t_nxt = 4'd0;
        w_hour_u_nxt = 4'd1;
      end else if (r_hour_t == 4'd1 && r_hour_u == 4'd1) begin
        w_hour_u_nxt = 4'd2;
        w_pm_toggle  = 1'b1;
      end else if (r_hour_u >= 4'd9) begin
        w_hour_t_nxt = 4'd1;
        w_hour_u_nxt = 4'd0;
      end else begin
        w_hour_u_nxt = r_hour_u + 4'd1;
      end
`else
      if (r_hour_t >= 4'd2 && r_hour_u >= 4'd3) begin
        w_hour_t_nxt = 4'd0;
        w_hour_u_nxt = 4'd0;
      end else if (r_hour_u >= 4'd9) begin
        w_hour_t_nxt = r_hour_t + 4'd1;
        w_hour_u_nxt = 4'd0;
      end else begin
        w_hour_u_nxt = r_hour_u + 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_t     <= 4'd0;
      r_min_u     <= 4'd0;
      r_hour_t    <= HOUR_RST[7:4];
      r_hour_u    <= HOUR_RST[3:0];
      r_carry_cnt <= '0;
    end else begin
      r_min_t  <= w_min_t_nxt;
      r_min_u  <= w_min_u_nxt;
      r_hour_t <= w_hour_t_nxt;
      r_hour_u <= w_hour_u_nxt;
      // A new wrap reloads the pulse length even if a pulse is still running.
      if (w_min_wrap)
        r_carry_cnt <= CW'(CARRY_LEN);
      else if (r_carry_cnt != '0)
        r_carry_cnt <= r_carry_cnt - CW'(1);
    end
  end

`ifdef HOUR12_EN
  logic r_pm;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pm <= 1'b0;
    else if (w_pm_toggle)
      r_pm <= ~r_pm;
  end
  assign bus.pm = r_pm;
`else
  assign bus.pm = 1'b0;
`endif

  assign bus.min_bcd  = {r_min_t, r_min_u};
  assign bus.hour_bcd = {r_hour_t, r_hour_u};
  assign bus.m_out    = (r_carry_cnt != '0);

endmodule

// File: tb/tb_time_hm_counter.sv
// Self-checking bench for time_hm_counter against an integer-time reference
// model; build with +define+HOUR12_EN to exercise the 12-hour variant.
module tb_time_hm_counter;

  localparam int S  = 2;
  localparam int CL = 3;
`ifdef HOUR12_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_inc_m = 1'b0;
  logic tb_inc_h = 1'b0;
  logic run_mode = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // reference model: plain integer time, carry length remaining, input history
  int e_min, e_hour, e_carry;
  bit e_pm;
  bit hist_m[S+2];
  bit hist_h[S+2];

  time_hm_counter_if bus ();
  assign bus.inc_m = tb_inc_m;
  assign bus.inc_h = run_mode ? bus.m_out : tb_inc_h;

  time_hm_counter #(.SYNC_STAGES(S), .CARRY_LEN(CL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic logic [7:0] hour_init();
    return H12 ? 8'h12 : 8'h00;
  endfunction

  task automatic model_reset();
    e_min = 0;
    e_hour = H12 ? 12 : 0;
    e_pm = 1'b0;
    e_carry = 0;
    for (int i = 0; i < S + 2; i++) begin
      hist_m[i] = 1'b0;
      hist_h[i] = 1'b0;
    end
  endtask

  // One rising edge: an input level seen at edge n steps the count at n+S
  // when it was low at the edge before.
  task automatic model_edge(input bit m, input bit h);
    bit sm, sh;
    for (int i = S + 1; i > 0; i--) begin
      hist_m[i] = hist_m[i-1];
      hist_h[i] = hist_h[i-1];
    end
    hist_m[0] = m;
    hist_h[0] = h;
    sm = hist_m[S] && !hist_m[S+1];
    sh = hist_h[S] && !hist_h[S+1];
    if (e_carry > 0) e_carry--;
    if (sm) begin
      e_min = (e_min + 1) % 60;
      if (e_min == 0) e_carry = CL;
    end
    if (sh) begin
      if (H12) begin
        if (e_hour == 11) begin e_hour = 12; e_pm = !e_pm; end
        else if (e_hour == 12) e_hour = 1;
        else e_hour++;
      end else begin
        e_hour = (e_hour + 1) % 24;
      end
    end
  endtask

  // Called at a falling edge; drives levels, advances one cycle, returns at next falling edge.
  task automatic tick(input logic m, input logic h);
    bit hl;
    hl = run_mode ? (e_carry != 0) : h;
    tb_inc_m = m;
    tb_inc_h = h;
    @(posedge clk);
    model_edge(m, hl);
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (S + 1) tick(1'b0, 1'b0);
  endtask

  task automatic pulse_m(input int n);
    for (int i = 0; i < n; i++) begin tick(1'b1, 1'b0); tick(1'b0, 1'b0); end
    drain();
  endtask

  task automatic pulse_h(input int n);
    for (int i = 0; i < n; i++) begin tick(1'b0, 1'b1); tick(1'b0, 1'b0); end
    drain();
  endtask

  task automatic apply_reset();
    tb_inc_m = 1'b0;
    tb_inc_h = 1'b0;
    run_mode = 1'b0;
    #3 rst_n = 1'b0;
    #1 model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fresh_start();
    apply_reset();
    release_reset();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.min_bcd !== 8'h00) begin failures++; $display("FAIL reset_min got=%h exp=00", bus.min_bcd); end
    checks++;
    if (bus.hour_bcd !== hour_init()) begin failures++; $display("FAIL reset_hour got=%h exp=%h", bus.hour_bcd, hour_init()); end
    checks++;
    if (bus.m_out !== 1'b0 || bus.pm !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.m_out, bus.pm); end
    release_reset();
    pulse_m(7);
    pulse_h(5);
    checks++;
    if (bus.min_bcd !== to_bcd(e_min) || bus.hour_bcd !== to_bcd(e_hour)) begin
      failures++; $display("FAIL precount got=%h:%h exp=%h:%h", bus.hour_bcd, bus.min_bcd, to_bcd(e_hour), to_bcd(e_min));
    end
    apply_reset();
    checks++;
    if (bus.min_bcd !== 8'h00 || bus.hour_bcd !== hour_init() || bus.m_out !== 1'b0) begin
      failures++; $display("FAIL midreset got=%h:%h m_out=%b exp=%h:00 m_out=0", bus.hour_bcd, bus.min_bcd, bus.m_out, hour_init());
    end
    release_reset();
  endtask

  task automatic test_min_wrap();
    bit saw_mout;
    int j_min, j_mo, n_mo;
    fresh_start();
    saw_mout = 1'b0;
    for (int i = 0; i < 59; i++) begin
      tick(1'b1, 1'b0); saw_mout |= bus.m_out;
      tick(1'b0, 1'b0); saw_mout |= bus.m_out;
    end
    drain();
    saw_mout |= bus.m_out;
    checks++;
    if (bus.min_bcd !== 8'h59) begin failures++; $display("FAIL min59 got=%h exp=59", bus.min_bcd); end
    checks++;
    if (saw_mout) begin failures++; $display("FAIL mout_early got=1 exp=0"); end
    tick(1'b1, 1'b0);
    j_min = -1; j_mo = -1; n_mo = 0;
    for (int j = 1; j <= S + CL + 4; j++) begin
      tick(1'b0, 1'b0);
      if (j_min < 0 && bus.min_bcd === 8'h00) j_min = j;
      if (bus.m_out === 1'b1) begin n_mo++; if (j_mo < 0) j_mo = j; end
    end
    checks++;
    if (j_min != S) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", j_min, S); end
    checks++;
    if (j_mo != S) begin failures++; $display("FAIL mout_start got=%0d exp=%0d", j_mo, S); end
    checks++;
    if (n_mo != CL) begin failures++; $display("FAIL mout_width got=%0d exp=%0d", n_mo, CL); end
  endtask

  task automatic test_hour_hold();
    int j_chg, n_chg;
    logic [7:0] prev;
    fresh_start();
    pulse_h(H12 ? 11 : 23);
    checks++;
    if (bus.hour_bcd !== (H12 ? 8'h11 : 8'h23)) begin failures++; $display("FAIL hour_preset got=%h", bus.hour_bcd); end
    j_chg = -1; n_chg = 0;
    for (int i = 0; i < 100; i++) begin
      prev = bus.hour_bcd;
      tick(1'b0, 1'b1);
      if (bus.hour_bcd !== prev) begin n_chg++; if (j_chg < 0) j_chg = i; end
    end
    checks++;
    if (j_chg != S || n_chg != 1) begin failures++; $display("FAIL hold_step got=at%0d x%0d exp=at%0d x1", j_chg, n_chg, S); end
    checks++;
    if (bus.hour_bcd !== (H12 ? 8'h12 : 8'h00)) begin failures++; $display("FAIL hold_value got=%h exp=%h", bus.hour_bcd, H12 ? 8'h12 : 8'h00); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    drain();
    checks++;
    if (bus.hour_bcd !== 8'h01) begin failures++; $display("FAIL rearm_step got=%h exp=01", bus.hour_bcd); end
  endtask

  task automatic test_simultaneous();
    fresh_start();
    for (int i = 0; i < 9; i++) begin tick(1'b1, 1'b1); tick(1'b0, 1'b0); end
    drain();
    checks++;
    if (bus.min_bcd !== 8'h09 || bus.hour_bcd !== 8'h09) begin failures++; $display("FAIL both09 got=%h:%h exp=09:09", bus.hour_bcd, bus.min_bcd); end
    tick(1'b1, 1'b1);
    for (int j = 1; j <= S; j++) begin
      tick(1'b0, 1'b0);
      if (j == S - 1) begin
        checks++;
        if (bus.min_bcd !== 8'h09 || bus.hour_bcd !== 8'h09) begin failures++; $display("FAIL both_early got=%h:%h exp=09:09", bus.hour_bcd, bus.min_bcd); end
      end
      if (j == S) begin
        checks++;
        if (bus.min_bcd !== 8'h10 || bus.hour_bcd !== 8'h10) begin failures++; $display("FAIL both10 got=%h:%h exp=10:10", bus.hour_bcd, bus.min_bcd); end
      end
    end
  endtask

  task automatic test_run_loop();
    int j_mo, j_h;
    logic [7:0] h0;
    fresh_start();
    pulse_h(H12 ? 11 : 23);
    pulse_m(59);
    run_mode = 1'b1;
    h0 = bus.hour_bcd;
    tick(1'b1, 1'b0);
    j_mo = -1; j_h = -1;
    for (int j = 1; j <= 2 * S + CL + 4; j++) begin
      tick(1'b0, 1'b0);
      if (j_mo < 0 && bus.m_out === 1'b1) j_mo = j;
      if (j_h < 0 && bus.hour_bcd !== h0) j_h = j;
    end
    checks++;
    if (j_mo != S) begin failures++; $display("FAIL loop_mout got=%0d exp=%0d", j_mo, S); end
    checks++;
    if (j_h != 2 * S + 1) begin failures++; $display("FAIL loop_hour_lat got=%0d exp=%0d", j_h, 2 * S + 1); end
    checks++;
    if (bus.min_bcd !== 8'h00 || bus.hour_bcd !== (H12 ? 8'h12 : 8'h00) || bus.pm !== H12) begin
      failures++; $display("FAIL loop_time got=%h:%h pm=%b exp=%h:00 pm=%b", bus.hour_bcd, bus.min_bcd, bus.pm, H12 ? 8'h12 : 8'h00, H12);
    end
    run_mode = 1'b0;
  endtask

  task automatic test_random();
    logic m, h;
    int bad;
    fresh_start();
    m = 1'b0; h = 1'b0; bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) run_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) m = ~m;
      if ($urandom_range(0, 5) == 0) h = ~h;
      tick(m, h);
      checks++;
      if (bus.min_bcd !== to_bcd(e_min) || bus.hour_bcd !== to_bcd(e_hour) ||
          bus.m_out !== (e_carry != 0) || bus.pm !== e_pm) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL random cyc=%0d got=%h:%h m_out=%b pm=%b exp=%h:%h m_out=%b pm=%b", i,
                   bus.hour_bcd, bus.min_bcd, bus.m_out, bus.pm,
                   to_bcd(e_hour), to_bcd(e_min), e_carry != 0, e_pm);
      end
    end
    run_mode = 1'b0;
    tick(1'b0, 1'b0);
  endtask

`ifdef HOUR12_EN
  task automatic test_pm();
    fresh_start();
    pulse_h(11);
    checks++;
    if (bus.hour_bcd !== 8'h11 || bus.pm !== 1'b0) begin failures++; $display("FAIL pm_11am got=%h pm=%b exp=11 pm=0", bus.hour_bcd, bus.pm); end
    pulse_h(1);
    checks++;
    if (bus.hour_bcd !== 8'h12 || bus.pm !== 1'b1) begin failures++; $display("FAIL pm_12pm got=%h pm=%b exp=12 pm=1", bus.hour_bcd, bus.pm); end
    pulse_h(1);
    checks++;
    if (bus.hour_bcd !== 8'h01 || bus.pm !== 1'b1) begin failures++; $display("FAIL pm_1pm got=%h pm=%b exp=01 pm=1", bus.hour_bcd, bus.pm); end
  endtask
`endif

  task automatic test_reset_during_carry();
    bool_wait: begin end
    fresh_start();
    pulse_m(59);
    tick(1'b1, 1'b0);
    for (int j = 0; j < S + 2 && bus.m_out !== 1'b1; j++) tick(1'b0, 1'b0);
    checks++;
    if (bus.m_out !== 1'b1) begin failures++; $display("FAIL carry_seen got=0 exp=1"); end
    apply_reset();
    checks++;
    if (bus.m_out !== 1'b0 || bus.min_bcd !== 8'h00 || bus.hour_bcd !== hour_init()) begin
      failures++; $display("FAIL carry_abort got m_out=%b %h:%h exp m_out=0 %h:00", bus.m_out, bus.hour_bcd, bus.min_bcd, hour_init());
    end
    release_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #4;
    test_reset();
    test_min_wrap();
    test_hour_hold();
    test_simultaneous();
    test_run_loop();
    test_reset_during_carry();
`ifdef HOUR12_EN
    test_pm();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
